// File: rtl/fetch_sequencer_pkg.sv
// Package fetch_pkg: shared state encoding, default parameter values and the
// address alignment helper used by the fetch sequencer.
// No ports.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    localparam int          DEF_ADDR_W       = 32;
    localparam int          DEF_DATA_W       = 32;
    localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
    localparam int unsigned DEF_INC          = 4;
    localparam int unsigned DEF_TIMEOUT      = 16;

    // Clears the low log2(inc) bits. Works on a 64-bit carrier so any
    // ADDR_W up to 64 can use it; callers cast back to their own width.
    // inc must be a power of two.
    function automatic logic [63:0] align(input logic [63:0] addr, input int unsigned inc);
        return addr & ~(64'(inc) - 64'd1);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory-side handshake between the fetch sequencer and instruction memory.
//   mem_enable : request, held high until MOC
//   mem_addr   : fetch address, stable while mem_enable is high
//   MOC        : memory operation complete, mem_rdata valid in the same cycle
//   mem_rdata  : instruction word
// master = sequencer side, slave = memory side.
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              mem_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic              MOC;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_enable,
        output mem_addr,
        input  MOC,
        input  mem_rdata
    );

    modport slave (
        input  mem_enable,
        input  mem_addr,
        output MOC,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_sequencer_pc_register.sv
// pc_register: program counter with synchronous reset, a load port and an
// increment port. Load wins over increment when both are asserted.
//   clk, reset  : clock and synchronous active-high reset
//   load_en     : load load_value
//   load_value  : new PC
//   inc_en      : add inc_step
//   inc_step    : increment amount
//   pc          : current PC
module pc_register #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc_en,
    input  logic [ADDR_W-1:0] inc_step,
    output logic [ADDR_W-1:0] pc
);

    // Arithmetic wraps modulo 2^ADDR_W on purpose.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else if (load_en) begin
            pc <= load_value;
        end else if (inc_en) begin
            pc <= pc + inc_step;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter plus fetch FSM. Issues one instruction
// fetch at a time to memory, hands the result to decode with valid/ready,
// supports branch/jump redirect (aborting an in-flight fetch) and reports a
// sticky error when memory fails to answer within TIMEOUT cycles.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   stall            : hold off starting a new fetch
//   redirect_valid   : one-cycle pulse, load redirect_target into pc
//   redirect_target  : new PC (low log2(INC) bits ignored)
//   mem              : memory handshake (master side)
//   ir, ir_pc        : fetched instruction and its address
//   ir_valid         : ir holds an unconsumed instruction
//   ir_ready         : decode accepts ir
//   pc               : address of the next fetch
//   npc              : ir_pc + INC (combinational)
//   fetch_error      : sticky memory-timeout flag
//
// state | meaning
// IDLE  | no access outstanding; start a fetch unless stalled/redirected
// WAIT  | request outstanding, data will be kept
// HOLD  | ir_valid high, waiting for decode to take ir
// DRAIN | request outstanding after a redirect, data will be dropped
// FAULT | memory timed out; only redirect or reset leaves
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                DATA_W       = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter int unsigned       INC          = DEF_INC,
    parameter int unsigned       TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_target,
    fetch_sequencer_if.master        mem,
    output logic [DATA_W-1:0]        ir,
    output logic [ADDR_W-1:0]        ir_pc,
    output logic                     ir_valid,
    input  logic                     ir_ready,
    output logic [ADDR_W-1:0]        pc,
    output logic [ADDR_W-1:0]        npc,
    output logic                     fetch_error
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] WAIT  = ST_WAIT;
    localparam logic [2:0] HOLD  = ST_HOLD;
    localparam logic [2:0] DRAIN = ST_DRAIN;
    localparam logic [2:0] FAULT = ST_FAULT;

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    // The fault fires on the edge that would make the count equal TIMEOUT,
    // so fetch_error rises exactly TIMEOUT cycles after mem_enable.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] INC_STEP = ADDR_W'(INC);

    logic [2:0]        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] redirect_pc;
    logic              timeout_hit;
    logic              pc_inc;

    assign redirect_pc = ADDR_W'(align(64'(redirect_target), INC));
    assign timeout_hit = (TIMEOUT != 0) && !mem.MOC && (wait_cnt == CNT_LAST);
    // A redirect in the completing cycle leaves pc at the target.
    assign pc_inc      = (state == WAIT) && mem.MOC && !redirect_valid;
    assign npc         = ir_pc + INC_STEP;

    pc_register #(
        .ADDR_W       (ADDR_W),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_en    (redirect_valid),
        .load_value (redirect_pc),
        .inc_en     (pc_inc),
        .inc_step   (INC_STEP),
        .pc         (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            mem.mem_enable <= 1'b0;
            mem.mem_addr   <= '0;
            ir             <= '0;
            ir_pc          <= '0;
            ir_valid       <= 1'b0;
            fetch_error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!stall && !redirect_valid) begin
                        mem.mem_addr   <= pc;
                        mem.mem_enable <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.MOC) begin
                        mem.mem_enable <= 1'b0;
                        if (redirect_valid) begin
                            state <= IDLE;
                        end else begin
                            ir       <= mem.mem_rdata;
                            ir_pc    <= mem.mem_addr;
                            ir_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end else if (timeout_hit) begin
                        // Timeout wins over a same-cycle redirect; pc still
                        // takes the target so the next redirect is a clean restart.
                        mem.mem_enable <= 1'b0;
                        fetch_error    <= 1'b1;
                        state          <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (redirect_valid) begin
                            state <= DRAIN;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid || ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DRAIN: begin
                    // The access keeps its original counter: the memory is
                    // still working on the same request.
                    if (mem.MOC) begin
                        mem.mem_enable <= 1'b0;
                        state          <= IDLE;
                    end else if (timeout_hit) begin
                        mem.mem_enable <= 1'b0;
                        fetch_error    <= 1'b1;
                        state          <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                FAULT: begin
                    if (redirect_valid) begin
                        fetch_error <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    mem.mem_enable <= 1'b0;
                    ir_valid       <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, redirect_valid, ir_ready;
    logic [31:0] redirect_target;
    logic [31:0] ir, ir_pc, pc, npc;
    logic        ir_valid, fetch_error;

    logic        stall_b, redirect_b, ready_b;
    logic [7:0]  target_b, ir_pc_b, pc_b, npc_b;
    logic [15:0] ir_b;
    logic        iv_b, fe_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(32), .DATA_W(32)) mbus ();
    fetch_sequencer_if #(.ADDR_W(8),  .DATA_W(16)) mbus_b ();

    fetch_sequencer #(
        .ADDR_W(32), .DATA_W(32), .RESET_VECTOR(32'h0), .INC(4), .TIMEOUT(5)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .mem(mbus.master), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .pc(pc), .npc(npc), .fetch_error(fetch_error)
    );

    fetch_sequencer #(
        .ADDR_W(8), .DATA_W(16), .RESET_VECTOR(8'h0), .INC(4), .TIMEOUT(0)
    ) dut_b (
        .clk(clk), .reset(reset), .stall(stall_b),
        .redirect_valid(redirect_b), .redirect_target(target_b),
        .mem(mbus_b.master), .ir(ir_b), .ir_pc(ir_pc_b), .ir_valid(iv_b),
        .ir_ready(ready_b), .pc(pc_b), .npc(npc_b), .fetch_error(fe_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0; ir_ready = 1'b0;
        mbus.MOC = 1'b0; mbus.mem_rdata = '0;
        stall_b = 1'b1; redirect_b = 1'b0; target_b = '0; ready_b = 1'b0;
        mbus_b.MOC = 1'b0; mbus_b.mem_rdata = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_pc;
    } redir_vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    initial begin
        redir_vec_t vecs[6];
        int          iss_e[$];
        logic [31:0] iss_a[$];
        logic        prev_me;
        ent_t        q[$];
        logic [31:0] exp_next, cur_addr;
        bit          outstanding, discard, idle_now;
        int          lat, deliveries;

        vecs[0] = '{32'h0000_0103, 32'h0000_0100};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[2] = '{32'h0000_0040, 32'h0000_0040};
        vecs[3] = '{32'h0000_0002, 32'h0000_0000};
        vecs[4] = '{32'h8000_0006, 32'h8000_0004};
        vecs[5] = '{32'h1234_5679, 32'h1234_5678};

        @(negedge clk);

        // Reset values, then one fetch with MOC in the 2nd WAIT cycle.
        do_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_mem_en", 32'(mbus.mem_enable), 32'h0);
        check("rst_mem_addr", mbus.mem_addr, 32'h0);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_ir_pc", ir_pc, 32'h0);
        check("rst_err", 32'(fetch_error), 32'h0);
        step();
        check("t1_mem_en", 32'(mbus.mem_enable), 32'h1);
        check("t1_mem_addr", mbus.mem_addr, 32'h0);
        step();
        check("t1_no_ir_yet", 32'(ir_valid), 32'h0);
        mbus.MOC = 1'b1; mbus.mem_rdata = 32'h2008_0005; ir_ready = 1'b1;
        step();
        mbus.MOC = 1'b0;
        check("t1_ir_valid", 32'(ir_valid), 32'h1);
        check("t1_ir", ir, 32'h2008_0005);
        check("t1_ir_pc", ir_pc, 32'h0);
        check("t1_pc", pc, 32'h4);
        check("t1_npc", npc, 32'h4);
        check("t1_mem_en_drop", 32'(mbus.mem_enable), 32'h0);
        step();
        check("t1_consumed", 32'(ir_valid), 32'h0);

        // Back-to-back fetches with immediate MOC; stall for edges 10..13.
        do_reset();
        ir_ready = 1'b1;
        prev_me = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            stall = (e >= 10 && e <= 13);
            mbus.MOC = mbus.mem_enable;
            mbus.mem_rdata = mem_word(mbus.mem_addr);
            step();
            if (mbus.mem_enable && !prev_me) begin
                iss_e.push_back(e);
                iss_a.push_back(mbus.mem_addr);
            end
            prev_me = mbus.mem_enable;
        end
        mbus.MOC = 1'b0; stall = 1'b0;
        check("b2b_issue_count", 32'(iss_e.size()), 32'd4);
        if (iss_e.size() == 4) begin
            check("b2b_edge0", 32'(iss_e[0]), 32'd1);
            check("b2b_edge1", 32'(iss_e[1]), 32'd4);
            check("b2b_edge2", 32'(iss_e[2]), 32'd7);
            check("b2b_stall_edge", 32'(iss_e[3]), 32'd14);
            check("b2b_addr0", iss_a[0], 32'h0);
            check("b2b_addr1", iss_a[1], 32'h4);
            check("b2b_addr2", iss_a[2], 32'h8);
            check("b2b_addr3", iss_a[3], 32'hC);
        end

        // Redirect during WAIT, MOC two cycles later: data discarded.
        do_reset();
        step();
        check("rd_issue", 32'(mbus.mem_enable), 32'h1);
        redirect_valid = 1'b1; redirect_target = 32'h103;
        step();
        redirect_valid = 1'b0;
        check("rd_drain_mem_en", 32'(mbus.mem_enable), 32'h1);
        check("rd_pc", pc, 32'h100);
        step();
        mbus.MOC = 1'b1; mbus.mem_rdata = 32'hDEAD_BEEF;
        step();
        mbus.MOC = 1'b0;
        check("rd_mem_en_drop", 32'(mbus.mem_enable), 32'h0);
        check("rd_no_ir_valid", 32'(ir_valid), 32'h0);
        step();
        check("rd_next_issue", 32'(mbus.mem_enable), 32'h1);
        check("rd_next_addr", mbus.mem_addr, 32'h100);
        check("rd_still_no_ir", 32'(ir_valid), 32'h0);

        // Timeout (TIMEOUT = 5) and recovery by redirect.
        do_reset();
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            check("to_err_early", 32'(fetch_error), 32'h0);
            check("to_mem_en_held", 32'(mbus.mem_enable), 32'h1);
        end
        step();
        check("to_err_rise", 32'(fetch_error), 32'h1);
        check("to_mem_en_drop", 32'(mbus.mem_enable), 32'h0);
        step();
        step();
        check("to_err_sticky", 32'(fetch_error), 32'h1);
        check("to_no_issue", 32'(mbus.mem_enable), 32'h0);
        redirect_valid = 1'b1; redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("to_err_clear", 32'(fetch_error), 32'h0);
        check("to_pc", pc, 32'h40);
        step();
        check("to_issue", 32'(mbus.mem_enable), 32'h1);
        check("to_issue_addr", mbus.mem_addr, 32'h40);

        // Redirect together with ir_ready in HOLD.
        do_reset();
        step();
        mbus.MOC = 1'b1; mbus.mem_rdata = 32'h1111_2222;
        step();
        mbus.MOC = 1'b0;
        check("hr_ir_valid", 32'(ir_valid), 32'h1);
        redirect_valid = 1'b1; redirect_target = 32'h200; ir_ready = 1'b1;
        step();
        redirect_valid = 1'b0; ir_ready = 1'b0;
        check("hr_ir_valid_drop", 32'(ir_valid), 32'h0);
        check("hr_pc", pc, 32'h200);
        step();
        check("hr_issue", 32'(mbus.mem_enable), 32'h1);
        check("hr_issue_addr", mbus.mem_addr, 32'h200);

        // Reset in the middle of a fetch.
        do_reset();
        step();
        reset = 1'b1; mbus.MOC = 1'b1; mbus.mem_rdata = 32'hABCD_0123;
        step();
        reset = 1'b0; mbus.MOC = 1'b0;
        check("rm_mem_en", 32'(mbus.mem_enable), 32'h0);
        check("rm_ir_valid", 32'(ir_valid), 32'h0);
        check("rm_pc", pc, 32'h0);

        // Table of redirect alignments while stalled in IDLE.
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            redirect_valid = 1'b1; redirect_target = vecs[i].target;
            step();
            redirect_valid = 1'b0;
            check($sformatf("tbl_pc[%0d]", i), pc, vecs[i].exp_pc);
            check($sformatf("tbl_mem_en[%0d]", i), 32'(mbus.mem_enable), 32'h0);
        end
        stall = 1'b0;

        // 8-bit instance: no timeout when disabled, PC wraps to 0.
        do_reset();
        stall = 1'b1;
        redirect_b = 1'b1; target_b = 8'hFE;
        step();
        redirect_b = 1'b0; stall_b = 1'b0;
        check("w_pc_aligned", 32'(pc_b), 32'hFC);
        step();
        stall_b = 1'b1;
        check("w_issue", 32'(mbus_b.mem_enable), 32'h1);
        check("w_issue_addr", 32'(mbus_b.mem_addr), 32'hFC);
        for (int k = 0; k < 20; k++) step();
        check("w_no_timeout", 32'(fe_b), 32'h0);
        check("w_mem_en_held", 32'(mbus_b.mem_enable), 32'h1);
        mbus_b.MOC = 1'b1; mbus_b.mem_rdata = 16'hBEEF;
        step();
        mbus_b.MOC = 1'b0;
        check("w_ir_valid", 32'(iv_b), 32'h1);
        check("w_ir", 32'(ir_b), 32'hBEEF);
        check("w_ir_pc", 32'(ir_pc_b), 32'hFC);
        check("w_pc_wrap", 32'(pc_b), 32'h00);
        check("w_npc_wrap", 32'(npc_b), 32'h00);
        ready_b = 1'b1;
        step();
        ready_b = 1'b0;
        check("w_consumed", 32'(iv_b), 32'h0);
        stall = 1'b0;

        // Random traffic against a transaction-level model.
        do_reset();
        exp_next = 32'h0; outstanding = 1'b0; discard = 1'b0; lat = 0;
        cur_addr = 32'h0; deliveries = 0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            check("rnd_mem_en", 32'(mbus.mem_enable), 32'(outstanding));
            if (outstanding) check("rnd_mem_addr", mbus.mem_addr, cur_addr);
            check("rnd_pc", pc, exp_next);
            check("rnd_ir_valid", 32'(ir_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("rnd_ir_pc", ir_pc, q[0].a);
                check("rnd_ir", ir, q[0].d);
                check("rnd_npc", npc, q[0].a + 32'd4);
            end
            check("rnd_err", 32'(fetch_error), 32'h0);

            idle_now = !outstanding && (q.size() == 0);
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_target = $urandom;
            ir_ready = ($urandom_range(0, 1) == 1);
            mbus.MOC = outstanding && (lat == 0);
            mbus.mem_rdata = mbus.MOC ? mem_word(cur_addr) : $urandom;

            if (outstanding) begin
                if (lat == 0) begin
                    outstanding = 1'b0;
                    if (!discard && !redirect_valid) begin
                        q.push_back('{cur_addr, mem_word(cur_addr)});
                        exp_next = cur_addr + 32'd4;
                    end
                end else begin
                    lat--;
                end
            end else if (q.size() != 0) begin
                if (redirect_valid) begin
                    q.delete();
                end else if (ir_ready) begin
                    void'(q.pop_front());
                    deliveries++;
                end
            end
            if (redirect_valid) begin
                exp_next = redirect_target & ~32'd3;
                if (outstanding) discard = 1'b1;
            end
            if (idle_now && !stall && !redirect_valid) begin
                outstanding = 1'b1;
                cur_addr = exp_next;
                discard = 1'b0;
                lat = $urandom_range(0, 3);
            end
            step();
        end
        redirect_valid = 1'b0; mbus.MOC = 1'b0; stall = 1'b1;
        check("rnd_progress", 32'(deliveries > 100), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
